// File: rtl/dp_execute_stage.sv
// dp_execute_stage: ARM data-processing ALU stage with flag register and valid/ready output register.
// Optional one-entry output skid buffer enabled by defining DP_EXECUTE_SKID_EN.
module dp_execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_op,
  input  logic [31:0] rn,
  input  logic [31:0] op2,
  input  logic        shifter_c,
  input  logic        s_bit,
  input  logic        cond_pass,
  output logic        carry_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        write_en,
  output logic [3:0]  nzcv
);
  logic        arith, test, rev, inv, c_in, v, we, upd, accept;
  logic [31:0] a, b, lres, res;
  logic [32:0] sum;
  logic [3:0]  flags;
  // Reverse ops swap operands; subtracts feed the inverted addend into one adder.
  always_comb begin
    arith = alu_op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB};
    test  = alu_op[3:2] == 2'b10;
    rev   = alu_op == 4'h3 || alu_op == 4'h7;
    inv   = alu_op inside {4'h2, 4'h6, 4'hA};
    a     = rev ? op2 : rn;
    b     = rev ? ~rn : inv ? ~op2 : op2;
    c_in  = alu_op inside {4'h4, 4'hB} ? 1'b0 : alu_op inside {4'h2, 4'h3, 4'hA} ? 1'b1 : nzcv[1];
    sum   = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
    v     = (a[31] == b[31]) && (sum[31] != a[31]);
    lres  = (alu_op == 4'h0 || alu_op == 4'h8) ? rn & op2 :
            (alu_op == 4'h1 || alu_op == 4'h9) ? rn ^ op2 :
            alu_op == 4'hC ? rn | op2 :
            alu_op == 4'hD ? op2 :
            alu_op == 4'hE ? rn & ~op2 : ~op2;
    res   = arith ? sum[31:0] : lres;
    we    = !test && cond_pass;
    upd   = cond_pass && (test || s_bit);
    flags = {res[31], res == 32'd0, arith ? sum[32] : shifter_c, arith ? v : nzcv[0]};
  end
  assign carry_flag = nzcv[1];
  assign accept     = in_valid && in_ready;
`ifdef DP_EXECUTE_SKID_EN
  logic        skid_full, skid_we;
  logic [31:0] skid_res;
  assign in_ready = !skid_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
      write_en  <= 1'b0;
      nzcv      <= 4'b0000;
      skid_full <= 1'b0;
      skid_res  <= 32'd0;
      skid_we   <= 1'b0;
    end else begin
      if (skid_full) begin
        if (out_ready) begin
          result    <= skid_res;
          write_en  <= skid_we;
          skid_full <= 1'b0;
        end
      end else if (accept && out_valid && !out_ready) begin
        skid_full <= 1'b1;
        skid_res  <= res;
        skid_we   <= we;
      end else if (accept) begin
        out_valid <= 1'b1;
        result    <= res;
        write_en  <= we;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && upd) nzcv <= flags;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
      write_en  <= 1'b0;
      nzcv      <= 4'b0000;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        result    <= res;
        write_en  <= we;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && upd) nzcv <= flags;
    end
  end
`endif
endmodule

// File: tb/tb_dp_execute_stage.sv
// tb_dp_execute_stage: scoreboard bench for dp_execute_stage; a reference ALU model predicts each accepted op.
module tb_dp_execute_stage;
  localparam logic [3:0] ADD = 4'h4, ADC = 4'h5, SUB = 4'h2, CMP = 4'hA, MOV = 4'hD;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  alu_op = 4'h0;
  logic [31:0] rn = 32'd0, op2 = 32'd0;
  logic        shifter_c = 1'b0, s_bit = 1'b0, cond_pass = 1'b1;
  logic        in_ready, carry_flag, out_valid, write_en;
  logic [31:0] result;
  logic [3:0]  nzcv;
  int          n_checks = 0, n_fail = 0;
  logic [32:0] sb[$];
  logic [3:0]  mf = 4'b0000;
  logic [36:0] m;
  logic [32:0] e;

  always #5 clk = ~clk;

  dp_execute_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rn(rn), .op2(op2), .shifter_c(shifter_c), .s_bit(s_bit),
    .cond_pass(cond_pass), .carry_flag(carry_flag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .write_en(write_en), .nzcv(nzcv)
  );

  // Returns {flags_after, write_en, result}.
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] x, y,
                                        input logic sc, s, cp, input logic [3:0] f);
    logic [32:0] t;
    logic [31:0] r;
    logic        c, v, ar, tst, upd;
    t = 33'd0; r = 32'd0; c = sc; v = f[0]; ar = 1'b1;
    case (op)
      4'h0, 4'h8: begin r = x & y; ar = 1'b0; end
      4'h1, 4'h9: begin r = x ^ y; ar = 1'b0; end
      4'hC: begin r = x | y; ar = 1'b0; end
      4'hD: begin r = y; ar = 1'b0; end
      4'hE: begin r = x & ~y; ar = 1'b0; end
      4'hF: begin r = ~y; ar = 1'b0; end
      4'h2, 4'hA: begin t = {1'b0, x} + {1'b0, ~y} + 33'd1; v = (x[31] != y[31]) && (t[31] != x[31]); end
      4'h6: begin t = {1'b0, x} + {1'b0, ~y} + {32'd0, f[1]}; v = (x[31] != y[31]) && (t[31] != x[31]); end
      4'h3: begin t = {1'b0, y} + {1'b0, ~x} + 33'd1; v = (y[31] != x[31]) && (t[31] != y[31]); end
      4'h7: begin t = {1'b0, y} + {1'b0, ~x} + {32'd0, f[1]}; v = (y[31] != x[31]) && (t[31] != y[31]); end
      4'h5: begin t = {1'b0, x} + {1'b0, y} + {32'd0, f[1]}; v = (x[31] == y[31]) && (t[31] != x[31]); end
      default: begin t = {1'b0, x} + {1'b0, y}; v = (x[31] == y[31]) && (t[31] != x[31]); end
    endcase
    if (ar) begin r = t[31:0]; c = t[32]; end
    tst = op >= 4'h8 && op <= 4'hB;
    upd = cp && (tst || s);
    return {upd ? {r[31], r == 32'd0, c, v} : f, !tst && cp, r};
  endfunction

  // Scoreboard: pop on output transfer, push on accept, flags tracked against the model.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      mf = 4'b0000;
    end else begin
      n_checks++;
      if (nzcv !== mf || carry_flag !== mf[1]) begin
        n_fail++;
        $display("FAIL sb_flags nzcv=%b carry_flag=%b expected nzcv=%b", nzcv, carry_flag, mf);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty unexpected output result=%h write_en=%b", result, write_en);
        end else begin
          e = sb.pop_front();
          if ({write_en, result} !== e) begin
            n_fail++;
            $display("FAIL sb_result got we=%b result=%h expected we=%b result=%h", write_en, result, e[32], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        m = model(alu_op, rn, op2, shifter_c, s_bit, cond_pass, mf);
        sb.push_back(m[32:0]);
        mf = m[36:33];
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] x, y, input logic sc, s, cp);
    logic acc;
    acc = 1'b0;
    alu_op = op; rn = x; op2 = y; shifter_c = sc; s_bit = s; cond_pass = cp; in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL send_timeout op=%h accepted=%b expected 1", op, acc); end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; alu_op = ADD; rn = 32'h1234; op2 = 32'h1; s_bit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h expected 0", result); end
    if (write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en got %b expected 0", write_en); end
    if (nzcv !== 4'b0000) begin n_fail++; $display("FAIL reset_nzcv got %b expected 0000", nzcv); end
    reset = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_adds;
    out_ready = 1'b1;
    send(ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 1'b1);
    n_checks += 4;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL adds_out_valid got %b expected 1", out_valid); end
    if (result !== 32'h80000000) begin n_fail++; $display("FAIL adds_result got %h expected 80000000", result); end
    if (nzcv !== 4'b1001) begin n_fail++; $display("FAIL adds_nzcv got %b expected 1001", nzcv); end
    if (write_en !== 1'b1) begin n_fail++; $display("FAIL adds_write_en got %b expected 1", write_en); end
  endtask

  task automatic test_cmp;
    send(CMP, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1);
    n_checks += 2;
    if (nzcv !== 4'b0110) begin n_fail++; $display("FAIL cmp_nzcv got %b expected 0110", nzcv); end
    if (write_en !== 1'b0) begin n_fail++; $display("FAIL cmp_write_en got %b expected 0", write_en); end
  endtask

  task automatic test_movs;
    send(ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 1'b1);
    send(MOV, 32'hDEAD, 32'd0, 1'b1, 1'b1, 1'b1);
    n_checks += 2;
    if (nzcv !== 4'b0111) begin n_fail++; $display("FAIL movs_nzcv got %b expected 0111", nzcv); end
    @(posedge clk); #1;
    if (carry_flag !== 1'b1) begin n_fail++; $display("FAIL movs_carry got %b expected 1", carry_flag); end
  endtask

  task automatic test_back_to_back;
    send(ADD, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 1'b1);
    n_checks += 3;
    if (result !== 32'd0) begin n_fail++; $display("FAIL b2b_adds_result got %h expected 0", result); end
    send(ADC, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    if (result !== 32'd3) begin n_fail++; $display("FAIL b2b_adc_result got %h expected 3", result); end
    if (nzcv !== 4'b0110) begin n_fail++; $display("FAIL b2b_nzcv got %b expected 0110", nzcv); end
  endtask

  task automatic test_stall;
    logic acc;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(ADD, 32'd1, 32'd2, 1'b0, 1'b1, 1'b1);
    alu_op = SUB; rn = 32'd10; op2 = 32'd3; s_bit = 1'b1; cond_pass = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got %b expected 1", out_valid); end
      if (result !== 32'd3) begin n_fail++; $display("FAIL stall_result got %h expected 3", result); end
`ifndef DP_EXECUTE_SKID_EN
      n_checks += 2;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b expected 0", in_ready); end
      if (nzcv !== 4'b0000) begin n_fail++; $display("FAIL stall_nzcv got %b expected 0000", nzcv); end
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks += 2;
    if (result !== 32'd7 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got valid=%b result=%h expected 1 7", out_valid, result); end
    @(posedge clk); #1;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_cond;
    out_ready = 1'b0;
    send(ADD, 32'd9, 32'd9, 1'b0, 1'b1, 1'b1);
    n_checks += 5;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_stall_valid got %b expected 1", out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    if (out_valid !== 1'b0 || nzcv !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_stall got valid=%b nzcv=%b expected 0 0000", out_valid, nzcv); end
    send(MOV, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    if (nzcv !== 4'b0110) begin n_fail++; $display("FAIL cond_prep_nzcv got %b expected 0110", nzcv); end
    send(ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 1'b0);
    if (out_valid !== 1'b1 || write_en !== 1'b0) begin n_fail++; $display("FAIL cond_fail_out got valid=%b we=%b expected 1 0", out_valid, write_en); end
    if (nzcv !== 4'b0110) begin n_fail++; $display("FAIL cond_fail_nzcv got %b expected 0110", nzcv); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      alu_op    = 4'($urandom);
      rn        = $urandom_range(0, 3) == 0 ? 32'h7FFFFFFF : $urandom;
      op2       = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom;
      shifter_c = 1'($urandom_range(0, 1));
      s_bit     = 1'($urandom_range(0, 1));
      cond_pass = $urandom_range(0, 4) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL random_drain queue=%0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_adds;
    test_cmp;
    test_movs;
    test_back_to_back;
    test_stall;
    test_reset_cond;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dp_execute_stage.md
DP_EXECUTE_STAGE -- requirements
Module: dp_execute_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  upstream presents an operation this cycle.
REQ-004 in_ready  output  1  stage accepts; transfer when in_valid && in_ready.
REQ-005 alu_op  input  4  ARM data-processing opcode: AND,EOR,SUB,RSB,ADD,ADC,SBC,RSC,TST,TEQ,CMP,CMN,ORR,MOV,BIC,MVN (0000..1111).
REQ-006 rn  input  32  first operand.
REQ-007 op2  input  32  second operand, the barrel-shifter result.
REQ-008 shifter_c  input  1  barrel-shifter carry-out.
REQ-009 s_bit  input  1  set-flags request.
REQ-010 cond_pass  input  1  condition code satisfied.
REQ-011 carry_flag  output  1  current C flag; drives the barrel shifter's carry input (RRX, carry-in).
REQ-012 out_valid  output  1  result register holds an operation.
REQ-013 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-014 result  output  32  registered ALU result.
REQ-015 write_en  output  1  registered destination-write enable.
REQ-016 nzcv  output  4  architectural flags {N,Z,C,V}, registered.

Function
REQ-017 Accept when in_valid && in_ready; capture result and write_en into the output register, which sets out_valid on the next edge; latency is 1 cycle.
REQ-018 Without the skid option, in_ready = !out_valid || out_ready, combinational.
REQ-019 out_valid clears after a downstream transfer unless a new accept occurs in the same cycle; a simultaneous drain and accept loads the new entry.
REQ-020 While out_valid && !out_ready, result and write_en hold stable.
REQ-021 Arithmetic ops use 33-bit sums: ADD rn+op2; ADC rn+op2+C; SUB rn+~op2+1; SBC rn+~op2+C; RSB op2+~rn+1; RSC op2+~rn+C; CMP as SUB; CMN as ADD.
REQ-022 For arithmetic ops, C is bit 32 of the sum and V is (a[31]==b'[31]) && (sum[31]!=a[31]), where b' is the possibly inverted addend.
REQ-023 Logical ops (AND,EOR,TST,TEQ,ORR,MOV,BIC,MVN) take C from shifter_c and leave V unchanged.
REQ-024 N = result[31] and Z = (result==0) for all flag updates.
REQ-025 TST, TEQ, CMP and CMN force write_en=0 and update flags regardless of s_bit.
REQ-026 Other ops set write_en=cond_pass and update flags only if s_bit && cond_pass.
REQ-027 When cond_pass=0, the operation still flows through: out_valid=1, write_en=0, flags unchanged.
REQ-028 Flags update on the accept edge, so an operation accepted on the next cycle sees the new carry_flag.
REQ-029 carry_flag = nzcv[1] at all times.
REQ-030 Without accept, nzcv never changes.

Reset
REQ-031 While reset is high at a clock edge: out_valid=0, result=0, write_en=0, nzcv=0000; this holds with in_valid high.
REQ-032 Reset mid-stall discards the held entry; no transfer is reported on that cycle.
REQ-033 in_ready is 1 in the first cycle after reset.

Configuration
REQ-034 Macro DP_EXECUTE_SKID_EN compiles in a one-entry skid buffer behind the output register.
REQ-035 With the macro, in_ready is a registered signal equal to !skid_full.
REQ-036 With the macro, an accept during stall fills the skid entry; the skid drains in order into the output register on the next out_ready.
REQ-037 With the macro, ordering is preserved and flags still update at accept.
REQ-038 Without the macro, there is no skid storage and REQ-018 applies.

Verification
REQ-039 Bench SHALL cover the ADDS case: rn=0x7FFFFFFF, op2=1, s_bit=1, cond_pass=1 -> result=0x80000000, nzcv=1001, write_en=1, out_valid on the next cycle.
REQ-040 Bench SHALL cover the CMP case: rn=5, op2=5, s_bit=0 -> nzcv=0110, write_en=0.
REQ-041 Bench SHALL cover the MOVS case: op2=0, shifter_c=1, prior V=1 -> nzcv=0111, with carry_flag=1 visible the next cycle.
REQ-042 Bench SHALL cover a back-to-back ADC after ADDS: 0xFFFFFFFF+1 (result 0, C=1), then ADC rn=1, op2=1 -> result=3.
REQ-043 Bench SHALL cover a stall: out_ready=0 for 3 cycles with in_valid=1 -> result stable, in_ready=0 (without the macro), no flag change after the first accept; release -> entries emerge in order.
REQ-044 Bench SHALL cover reset mid-stall and cond_pass=0: assert reset while out_valid=1 -> out_valid=0, nzcv=0000; an ADDS with cond_pass=0 -> out_valid=1, write_en=0, flags unchanged.
